// File: rtl/disto_sched.sv
// Sequences src/rec 4x4 block fetches through one shared TTransform and turns
// each returned sum pair into |rec - src| >> 5, plus a running macroblock total.
module disto_sched #(
  parameter int NUM_BLK = 16,
  parameter int TT_LAT  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] w,
  output logic         busy,
  output logic         blk_req,
  output logic [3:0]   blk_idx,
  output logic         blk_sel,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic [127:0] tt_in,
  output logic [255:0] tt_w,
  input  logic [31:0]  tt_sum,
  output logic         res_valid,
  output logic [3:0]   res_idx,
  output logic [31:0]  res_disto,
  output logic         done,
  output logic [31:0]  disto_total
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic [3:0] idx;
    logic       sel;
  } tag_t;

  localparam logic [4:0] LAST_REQ = 5'(2*NUM_BLK-1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_BLK-1);

  state_t            state;
  logic [4:0]        req_cnt;
  logic [TT_LAT:0]   vld_pipe;
  tag_t [TT_LAT:0]   tag_pipe;
  logic [31:0]       src_hold;
  logic              accept, cap;
  tag_t              cap_tag;
  logic signed [32:0] diff;
  logic [32:0]       mag;
  logic [31:0]       d;

  // req_cnt walks {idx, sel}, so src/rec of one block are fetched back-to-back
  assign blk_idx = req_cnt[4:1];
  assign blk_sel = req_cnt[0];
  assign accept  = blk_req & blk_valid;
  assign cap     = vld_pipe[TT_LAT];
  assign cap_tag = tag_pipe[TT_LAT];

  // 33-bit signed difference so full-range sums cannot wrap before the abs
  always_comb begin
    diff = $signed({tt_sum[31], tt_sum}) - $signed({src_hold[31], src_hold});
    mag  = diff[32] ? 33'(-diff) : 33'(diff);
    d    = 32'(mag >> 5);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= S_IDLE;
      req_cnt     <= '0;
      vld_pipe    <= '0;
      tag_pipe    <= '0;
      src_hold    <= '0;
      busy        <= 1'b0;
      blk_req     <= 1'b0;
      tt_in       <= '0;
      tt_w        <= '0;
      res_valid   <= 1'b0;
      res_idx     <= '0;
      res_disto   <= '0;
      done        <= 1'b0;
      disto_total <= '0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      vld_pipe  <= {vld_pipe[TT_LAT-1:0], accept};
      tag_pipe  <= {tag_pipe[TT_LAT-1:0], tag_t'(req_cnt)};
      if (accept) tt_in <= blk_data;

      if (cap) begin
        if (!cap_tag.sel) begin
          src_hold <= tt_sum;
        end else begin
          res_valid   <= 1'b1;
          res_idx     <= cap_tag.idx;
          res_disto   <= d;
          disto_total <= disto_total + d;
        end
      end

      case (state)
        S_IDLE: if (start) begin
          tt_w        <= w;
          disto_total <= '0;
          req_cnt     <= '0;
          busy        <= 1'b1;
          blk_req     <= 1'b1;
          state       <= S_FETCH;
        end
        S_FETCH: if (accept) begin
          if (req_cnt == LAST_REQ) begin
            blk_req <= 1'b0;
            state   <= S_DRAIN;
          end else begin
            req_cnt <= req_cnt + 5'd1;
          end
        end
        // the last rec tag is the youngest in flight, so its retirement empties the pipe
        S_DRAIN: if (cap && cap_tag.sel && cap_tag.idx == LAST_IDX) begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disto_sched.sv
// Bench for disto_sched: behavioural TTransform pipelines, scoreboard of
// expected per-block distortions built from the fetched data, directed steps.
module tb_disto_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         start0 = 1'b0, start1 = 1'b0;
  logic [255:0] w = '0;
  logic         blk_valid = 1'b1;
  logic [127:0] blk_data0 = '0, blk_data1 = '0;

  logic         busy0, blk_req0, blk_sel0, res_valid0, done0;
  logic [3:0]   blk_idx0, res_idx0;
  logic [127:0] tt_in0;
  logic [255:0] tt_w0;
  logic [31:0]  tt_sum0, res_disto0, disto_total0;

  logic         busy1, blk_req1, blk_sel1, res_valid1, done1;
  logic [3:0]   blk_idx1, res_idx1;
  logic [127:0] tt_in1;
  logic [255:0] tt_w1;
  logic [31:0]  tt_sum1, res_disto1, disto_total1;

  disto_sched #(.NUM_BLK(16), .TT_LAT(3)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .w(w), .busy(busy0),
    .blk_req(blk_req0), .blk_idx(blk_idx0), .blk_sel(blk_sel0),
    .blk_valid(blk_valid), .blk_data(blk_data0), .tt_in(tt_in0), .tt_w(tt_w0),
    .tt_sum(tt_sum0), .res_valid(res_valid0), .res_idx(res_idx0),
    .res_disto(res_disto0), .done(done0), .disto_total(disto_total0));

  disto_sched #(.NUM_BLK(1), .TT_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .w(w), .busy(busy1),
    .blk_req(blk_req1), .blk_idx(blk_idx1), .blk_sel(blk_sel1),
    .blk_valid(blk_valid), .blk_data(blk_data1), .tt_in(tt_in1), .tt_w(tt_w1),
    .tt_sum(tt_sum1), .res_valid(res_valid1), .res_idx(res_idx1),
    .res_disto(res_disto1), .done(done1), .disto_total(disto_total1));

  // TTransform: 4x4 Hadamard, then sum of w[i]*|coef[i]|
  function automatic int tt_fn(logic [127:0] px, logic [255:0] wt);
    int tmp [16];
    int a0, a1, a2, a3, s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a0 = int'(px[(4*i+0)*8 +: 8]) + int'(px[(4*i+2)*8 +: 8]);
      a1 = int'(px[(4*i+1)*8 +: 8]) + int'(px[(4*i+3)*8 +: 8]);
      a2 = int'(px[(4*i+1)*8 +: 8]) - int'(px[(4*i+3)*8 +: 8]);
      a3 = int'(px[(4*i+0)*8 +: 8]) - int'(px[(4*i+2)*8 +: 8]);
      tmp[4*i+0] = a0 + a1;
      tmp[4*i+1] = a3 + a2;
      tmp[4*i+2] = a3 - a2;
      tmp[4*i+3] = a0 - a1;
    end
    for (int i = 0; i < 4; i++) begin
      a0 = tmp[i] + tmp[8+i];
      a1 = tmp[4+i] + tmp[12+i];
      a2 = tmp[4+i] - tmp[12+i];
      a3 = tmp[i] - tmp[8+i];
      s += int'($signed(wt[16*(0+i) +: 16]))  * ((a0+a1) < 0 ? -(a0+a1) : (a0+a1));
      s += int'($signed(wt[16*(4+i) +: 16]))  * ((a3+a2) < 0 ? -(a3+a2) : (a3+a2));
      s += int'($signed(wt[16*(8+i) +: 16]))  * ((a3-a2) < 0 ? -(a3-a2) : (a3-a2));
      s += int'($signed(wt[16*(12+i) +: 16])) * ((a0-a1) < 0 ? -(a0-a1) : (a0-a1));
    end
    return s;
  endfunction

  int m0 [3];
  int m1 [3];
  always @(posedge clk) begin
    m0[0] <= tt_fn(tt_in0, tt_w0); m0[1] <= m0[0]; m0[2] <= m0[1];
    m1[0] <= tt_fn(tt_in1, tt_w1); m1[1] <= m1[0]; m1[2] <= m1[1];
  end
  assign tt_sum0 = m0[2];
  assign tt_sum1 = m1[2];

  // block data source
  int   pmode = 0;
  int   src_val = 0, rec_val = 0;
  bit   stall = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] gen(logic [3:0] idx, logic sel);
    logic [127:0] b;
    int v;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      v = sel ? rec_val : src_val;
      if (pmode == 1)      v = (k == 0) ? v : 0;
      else if (pmode == 2) v = int'(idx) * 13 + k * 29 + (sel ? 71 + k * k * 5 : 0);
      b[8*k +: 8] = 8'(v);
    end
    return b;
  endfunction

  initial forever begin
    @(posedge clk); #1;
    blk_valid = stall ? (cyc % 3 == 0) : 1'b1;
    blk_data0 = gen(blk_idx0, blk_sel0);
    blk_data1 = gen(blk_idx1, blk_sel1);
  end

  int ntests = 0, nfail = 0;
  task automatic check(string tag, longint obs, longint exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct { logic [3:0] idx; longint disto; } exp_t;
  exp_t         q [$];
  logic [255:0] w_run = '0;
  int           exp_src = 0;
  logic [4:0]   exp_ord = '0;
  longint       tot_exp = 0;
  int           nacc = 0, nres = 0, ndone = 0, nstray = 0;
  bit           done_seen = 0, quiet = 0, prev_req = 0, prev_vld = 0, prev_done = 0;
  int           done_cyc = 0;
  logic [4:0]   prev_is = '0;
  int           nres1 = 0, done1_cyc = 0;
  bit           done1_seen = 0;
  logic [31:0]  res1_last = '0;

  always @(negedge clk) begin
    int s;
    longint dl;
    exp_t e;
    if (!rst_n) begin
      if (prev_req && !prev_vld && blk_req0)
        check("stall_stable", {blk_idx0, blk_sel0}, prev_is);
      if (blk_req0 && blk_valid) begin
        check("accept_order", {blk_idx0, blk_sel0}, exp_ord);
        exp_ord++;
        nacc++;
        s = tt_fn(blk_data0, w_run);
        if (!blk_sel0) exp_src = s;
        else begin
          dl = longint'(s) - longint'(exp_src);
          if (dl < 0) dl = -dl;
          e.idx = blk_idx0;
          e.disto = dl >>> 5;
          q.push_back(e);
          tot_exp = (tot_exp + e.disto) & 64'hFFFF_FFFF;
        end
      end
      if (quiet && (res_valid0 || done0)) nstray++;
      if (res_valid0 && !quiet) begin
        nres++;
        check("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("res_idx", res_idx0, e.idx);
          check("res_disto", res_disto0, e.disto);
        end
      end
      if (done0) begin
        ndone++;
        done_seen = 1;
        done_cyc = cyc;
        check("done_with_res", res_valid0, 1);
        check("busy_at_done", busy0, 1);
      end
      if (prev_done) check("busy_after_done", busy0, 0);
      if (res_valid1) begin nres1++; res1_last = res_disto1; end
      if (done1) begin done1_seen = 1; done1_cyc = cyc; end
    end
    prev_req  = blk_req0;
    prev_vld  = blk_valid;
    prev_is   = {blk_idx0, blk_sel0};
    prev_done = done0;
  end

  int scyc = 0;

  task automatic clear_sb();
    q.delete();
    nacc = 0; nres = 0; ndone = 0; exp_ord = '0; tot_exp = 0; done_seen = 0;
    w_run = w;
  endtask

  task automatic run0(bit chk_lat);
    @(posedge clk); #1;
    clear_sb();
    start0 = 1'b1; scyc = cyc;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < 600 && !done_seen; i++) @(negedge clk);
    check("done_seen", done_seen, 1);
    if (chk_lat) check("done_latency", done_cyc - scyc, 37);
    check("total_model", disto_total0, tot_exp);
    check("res_count", nres, 16);
    check("accept_count", nacc, 32);
    check("sb_drained", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [255:0] w_only0(int v);
    logic [255:0] r;
    r = '0;
    r[15:0] = 16'(v);
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy0, 0);
    check("rst_blk_req", blk_req0, 0);
    check("rst_res_valid", res_valid0, 0);
    check("rst_done", done0, 0);
    check("rst_total", disto_total0, 0);
    check("rst_tt_in_zero", tt_in0 == '0, 1);
    check("rst_tt_w_zero", tt_w0 == '0, 1);
    check("rst_busy1", busy1, 0);
    rst_n = 1'b0;

    // flat blocks, +2 per pixel
    w = w_only0(1); pmode = 0; src_val = 10; rec_val = 12; stall = 0;
    run0(1);
    check("t1_total", disto_total0, 16);
    check("tt_w_held", tt_w0 == w_only0(1), 1);

    // same data with blk_valid every 3rd cycle
    stall = 1;
    run0(0);
    check("t2_total", disto_total0, 16);
    stall = 0;

    // negative difference
    src_val = 12; rec_val = 10;
    run0(1);
    check("t3_total", disto_total0, 16);

    // sums 0 vs 31 floor to zero
    pmode = 1; src_val = 0; rec_val = 31;
    run0(1);
    check("t3b_total", disto_total0, 0);

    // varied pixels and signed weights
    pmode = 2;
    for (int k = 0; k < 16; k++) w[16*k +: 16] = (k % 3 == 0) ? 16'(-(k + 1)) : 16'(k + 2);
    run0(1);

    // single-block instance
    pmode = 0; src_val = 0; rec_val = 255; w = w_only0(16);
    @(posedge clk); #1;
    done1_seen = 0; nres1 = 0;
    start1 = 1'b1; scyc = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 100 && !done1_seen; i++) @(negedge clk);
    check("nb1_done_seen", done1_seen, 1);
    check("nb1_latency", done1_cyc - scyc, 7);
    check("nb1_disto", res1_last, 2040);
    check("nb1_total", disto_total1, 2040);
    check("nb1_res_count", nres1, 1);

    // reset in the middle of a run
    w = w_only0(1); src_val = 10; rec_val = 12;
    @(posedge clk); #1;
    clear_sb();
    start0 = 1'b1; scyc = cyc;
    @(posedge clk); #1;
    start0 = 1'b0;
    while (cyc < scyc + 10) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; quiet = 1; nstray = 0;
    check("midrst_busy", busy0, 0);
    check("midrst_blk_req", blk_req0, 0);
    repeat (60) @(negedge clk);
    check("midrst_no_stray", nstray, 0);
    quiet = 0;
    run0(1);
    check("post_rst_total", disto_total0, 16);

    // start held high through most of a run
    @(posedge clk); #1;
    clear_sb();
    start0 = 1'b1; scyc = cyc;
    repeat (30) begin @(posedge clk); #1; end
    start0 = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("rep_start_accepts", nacc, 32);
    check("rep_start_done_count", ndone, 1);
    check("rep_start_total", disto_total0, 16);
    check("rep_start_idle", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/disto_sched.md
Name: disto_sched

Overview:
- Sequencer that time-shares one TTransform instance (3-cycle registered Hadamard-weighted-sum pipeline) to compute per-4x4-block spectral distortion for a macroblock.
- Per block: distortion = |TT(rec) - TT(src)| >> 5.
- Fetches source and reconstructed 4x4 blocks from an external buffer through a request/valid handshake, streams them back-to-back into the shared transform, and pairs the returned sums.
- Emits a per-block result and a macroblock total; sits between the block buffers and the mode-decision logic.

Parameters:
- NUM_BLK, 16, number of 4x4 blocks per run (1..16).
- TT_LAT, 3, cycles from tt_in/tt_w change to matching tt_sum.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse to begin a run; ignored while busy=1
- w  input  256  16 x 16-bit signed weights, sampled at start
- busy  output  1  high from the cycle after accepted start through the done cycle
- blk_req  output  1  fetch request
- blk_idx  output  4  block index requested
- blk_sel  output  1  0 = source, 1 = reconstructed
- blk_valid  input  1  fetch data valid; completes the request in that cycle
- blk_data  input  128  16 x 8-bit unsigned pixels, raster order
- tt_in  output  128  to shared TTransform pixel input
- tt_w  output  256  to shared TTransform weight input
- tt_sum  input  32  from shared TTransform
- res_valid  output  1  per-block result strobe
- res_idx  output  4  block index of result
- res_disto  output  32  per-block distortion
- done  output  1  one-cycle pulse, run complete
- disto_total  output  32  sum of all res_disto values of the run; valid when done=1, held until next start

Behaviour:
- Reset (rst_n=1 at posedge): state IDLE, all outputs 0, tag pipe cleared, accumulator 0. Mid-run reset aborts: no done, no further res_valid, blk_req drops next cycle.
- States:
  - IDLE: on start, latch w into tt_w reg, clear accumulator, go to FETCH.
  - FETCH: issue 2*NUM_BLK fetches in order (0,src),(0,rec),(1,src),...; go to DRAIN after final accept.
  - DRAIN: wait until tag pipe is empty and the last result has retired.
  - DONE: one cycle, done=1; return to IDLE.
- Handshake:
  - blk_req is high in every FETCH cycle; blk_idx/blk_sel are stable while blk_valid=0.
  - Accept = blk_req & blk_valid. On accept, tt_in <= blk_data and the request advances in the same edge. With blk_valid tied high, throughput is 1 block/cycle with no bubbles.
  - blk_valid is ignored when blk_req=0.
- Tag pipe: accept at cycle t sets a tag {valid, idx, sel} at depth TT_LAT+1; tt_sum for that block is present during cycle t+TT_LAT+1 and captured at the end of it.
- Pairing:
  - src sum is stored in a holding register.
  - When a rec sum is captured: d = rec - src as 33-bit signed, absolute value, then logical >>5 (floor).
  - Registered outputs: res_valid=1, res_idx, res_disto=d at cycle t_rec+TT_LAT+2.
  - Accumulator += d, modulo 2^32 (no saturation).
- Done and total: done coincides with the final res_valid; disto_total includes that block.
- tt_w is constant for the whole run. tt_in holds its last value when idle.
- Latency: with no stalls, start at cycle 0 gives first blk_req at 1, last accept at 2*NUM_BLK, done at 2*NUM_BLK+TT_LAT+2 (37 for defaults).
- start during busy: no effect. start in the DONE cycle: ignored; it must be re-issued in IDLE.

Test Plan:
- Flat blocks, w0=1, others 0, src all 10, rec all 12, blk_valid tied high. Sums are 160/192, so every res_disto=1; disto_total=16; done at cycle 37; 16 res_valid strobes in idx order 0..15.
- Same data, blk_valid asserted only on every 3rd cycle. Identical results; blk_idx/blk_sel stable while stalled; no duplicate or missing accepts.
- src all 12, rec all 10 (negative diff). res_disto=1 each; total=16. Also diff 31 (sums 0 vs 31, w0=1) gives res_disto=0, confirming floor.
- NUM_BLK=1 with w0=16: src zeros, rec all 255 (sum 4080*16=65280). res_disto=2040; total=2040; done at cycle 7.
- rst_n pulsed at cycle 10 of a run. No done, no res_valid afterwards, busy=0 next cycle; a fresh start afterwards gives correct totals with no stale tags.
- start pulsed repeatedly while busy. Single run only: exactly 2*NUM_BLK accepts, one done pulse.
